multicycle_control_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I subset R-type, LW, SW, BEQ and ADDI. It sits beside a shared-memory multi-cycle datapath (PC, OldPC, IR, A/B, ALUOut, MDR registers) and steps each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath mux select and write enable. It stalls on a memory ready handshake and flags unsupported opcodes.

---
 rtl/multicycle_control_fsm_pkg.sv | 37 +++
 rtl/multicycle_control_fsm_if.sv | 18 +
 rtl/multicycle_control_fsm_state_decode.sv | 66 ++++++
 rtl/multicycle_control_fsm.sv | 61 ++++++
 tb/tb_multicycle_control_fsm.sv | 136 +++++++++++++
 5 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_pkg: opcodes, state encoding and datapath select encodings for the multi-cycle control FSM
package multicycle_pkg;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_A     = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXEC, S_EXECI, S_ALUWB, S_BRANCH
  } state_e;
  // ir_write/pc_write/instr_done are raw here; the top qualifies them with mem_ready
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_done;
  } ctrl_t;
endpackage

// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: control sequencer <-> datapath/memory signal bundle
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic       zero, mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_en, branch, pc_source;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       reg_write, mem_to_reg, instr_done, illegal_op;
  modport ctrl (
    input  opcode, zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_en, branch, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, instr_done, illegal_op
  );
  modport dp (
    output opcode, zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_en, branch, pc_source,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control_fsm_state_decode.sv
// mc_state_decode: combinational state -> raw control vector
module mc_state_decode
  import multicycle_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_a = SRCA_PC;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a = SRCA_OLDPC;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = SRCA_A;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = SRCA_A;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        ctrl_o.alu_src_a = SRCA_A;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = SRCA_A;
        ctrl_o.alu_src_b  = SRCB_B;
        ctrl_o.alu_op     = ALU_SUB;
        ctrl_o.branch     = 1'b1;
        ctrl_o.pc_source  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: RV32I subset multi-cycle sequencer with memory-ready stalls and illegal-opcode flag
module multicycle_control_fsm
  import multicycle_pkg::*;
#(
  parameter bit STALL_ON_MEM = 1'b1
) (
  input logic clk,
  input logic reset,
  multicycle_control_fsm_if.ctrl bus
);
  state_e state_q, state_d;
  logic   illegal_q, illegal_d, rdy;
  ctrl_t  c, g;
  mc_state_decode u_dec (.state_i(state_q), .ctrl_o(c));
  assign rdy = STALL_ON_MEM ? bus.mem_ready : 1'b1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_d = (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) ? S_MEMADR :
                  (bus.opcode == OP_RTYPE)  ? S_EXEC   :
                  (bus.opcode == OP_IMM)    ? S_EXECI  :
                  (bus.opcode == OP_BRANCH) ? S_BRANCH : S_FETCH;
        illegal_d = (state_d == S_FETCH);
      end
      S_MEMADR: state_d = (bus.opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end
  // Everything is forced low while reset is held, even though the state already reads FETCH
  assign g = reset ? '0 : c;
  assign bus.mem_read   = g.mem_read;
  assign bus.mem_write  = g.mem_write;
  assign bus.iord       = g.iord;
  assign bus.ir_write   = g.ir_write & rdy;
  assign bus.pc_en      = (g.pc_write & rdy) | (g.branch & bus.zero);
  assign bus.branch     = g.branch;
  assign bus.pc_source  = g.pc_source;
  assign bus.alu_src_a  = g.alu_src_a;
  assign bus.alu_src_b  = g.alu_src_b;
  assign bus.alu_op     = g.alu_op;
  assign bus.reg_write  = g.reg_write;
  assign bus.mem_to_reg = g.mem_to_reg;
  assign bus.instr_done = g.instr_done & (rdy | state_q != S_MEMWR);
  assign bus.illegal_op = illegal_q & ~reset;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed per-cycle scoreboard check of the control sequencer
module tb_multicycle_control_fsm;
  import multicycle_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  multicycle_control_fsm_if b1 ();
  multicycle_control_fsm_if b2 ();
  multicycle_control_fsm #(.STALL_ON_MEM(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  multicycle_control_fsm #(.STALL_ON_MEM(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  assign b2.opcode    = b1.opcode;
  assign b2.zero      = b1.zero;
  assign b2.mem_ready = 1'b0;
  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, EX = 6, EXI = 7, AWB = 8, BR = 9, RST = 10;
  typedef struct {
    logic [16:0] v;
    bit          c2;
    string       tag;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int fails = 0;
  logic [16:0] o1, o2;
  assign o1 = {b1.mem_read, b1.mem_write, b1.iord, b1.ir_write, b1.pc_en, b1.branch, b1.pc_source,
               b1.alu_src_a, b1.alu_src_b, b1.alu_op, b1.reg_write, b1.mem_to_reg, b1.instr_done, b1.illegal_op};
  assign o2 = {b2.mem_read, b2.mem_write, b2.iord, b2.ir_write, b2.pc_en, b2.branch, b2.pc_source,
               b2.alu_src_a, b2.alu_src_b, b2.alu_op, b2.reg_write, b2.mem_to_reg, b2.instr_done, b2.illegal_op};
  function automatic logic [16:0] model(int st, bit rdy, bit z, bit ill);
    logic mr = 0, mw = 0, io = 0, irw = 0, pe = 0, br = 0, ps = 0, rw = 0, m2r = 0, dn = 0;
    logic [1:0] a = 2'b00, b = 2'b00, op = 2'b00;
    case (st)
      F:   begin mr = 1; b = 2'b01; irw = rdy; pe = rdy; end
      D:   begin a = 2'b10; b = 2'b10; end
      MA:  begin a = 2'b01; b = 2'b10; end
      MR:  begin mr = 1; io = 1; end
      MWB: begin rw = 1; m2r = 1; dn = 1; end
      MW:  begin mw = 1; io = 1; dn = rdy; end
      EX:  begin a = 2'b01; b = 2'b00; op = 2'b10; end
      EXI: begin a = 2'b01; b = 2'b10; op = 2'b10; end
      AWB: begin rw = 1; dn = 1; end
      BR:  begin a = 2'b01; op = 2'b01; br = 1; ps = 1; dn = 1; pe = z; end
      default: ;
    endcase
    return {mr, mw, io, irw, pe, br, ps, a, b, op, rw, m2r, dn, ill};
  endfunction
  task automatic cyc(int st, bit rdy, bit z, bit ill, bit rs, bit c2, string tag);
    @(posedge clk);
    #1;
    reset        = rs;
    b1.mem_ready = rdy;
    b1.zero      = z;
    q.push_back(exp_t'{rs ? 17'd0 : model(st, rdy, z, ill), c2, tag});
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      assert (o1 === e.v) else begin
        fails++;
        $error("FAIL %s stall_dut obs=%h exp=%h", e.tag, o1, e.v);
      end
      if (e.c2) begin
        checks++;
        assert (o2 === e.v) else begin
          fails++;
          $error("FAIL %s nostall_dut obs=%h exp=%h", e.tag, o2, e.v);
        end
      end
    end
  end
  initial begin
    b1.opcode = OP_LOAD;
    b1.zero = 1'b0;
    b1.mem_ready = 1'b1;
    cyc(RST, 1, 0, 0, 1, 0, "rst0");
    cyc(RST, 1, 0, 0, 1, 0, "rst1");
    cyc(F,   1, 0, 0, 0, 0, "lwx_fetch");
    cyc(D,   1, 0, 0, 0, 0, "lwx_decode");
    cyc(MA,  1, 0, 0, 0, 0, "lwx_memadr");
    cyc(MR,  0, 0, 0, 0, 0, "lwx_memrd0");
    cyc(MR,  0, 0, 0, 0, 0, "lwx_memrd1");
    cyc(RST, 0, 0, 0, 1, 0, "rst_mid0");
    cyc(RST, 1, 0, 0, 1, 0, "rst_mid1");
    cyc(F,   1, 0, 0, 0, 0, "lw_first_fetch");
    cyc(D,   1, 0, 0, 0, 0, "lw_decode");
    cyc(MA,  1, 0, 0, 0, 0, "lw_memadr");
    cyc(MR,  0, 0, 0, 0, 0, "lw_memrd_stall0");
    cyc(MR,  0, 0, 0, 0, 0, "lw_memrd_stall1");
    cyc(MR,  1, 0, 0, 0, 0, "lw_memrd_ready");
    cyc(MWB, 1, 0, 0, 0, 0, "lw_memwb");
    b1.opcode = OP_RTYPE;
    cyc(F,   1, 0, 0, 0, 0, "add_fetch");
    cyc(D,   1, 0, 0, 0, 0, "add_decode");
    cyc(EX,  1, 0, 0, 0, 0, "add_exec");
    cyc(AWB, 1, 0, 0, 0, 0, "add_aluwb");
    b1.opcode = OP_IMM;
    cyc(F,   0, 0, 0, 0, 0, "addi_fetch_stall");
    cyc(F,   1, 0, 0, 0, 0, "addi_fetch");
    cyc(D,   1, 0, 0, 0, 0, "addi_decode");
    cyc(EXI, 1, 0, 0, 0, 0, "addi_execi");
    cyc(AWB, 1, 0, 0, 0, 0, "addi_aluwb");
    b1.opcode = OP_BRANCH;
    cyc(F,   1, 1, 0, 0, 0, "beq1_fetch");
    cyc(D,   1, 1, 0, 0, 0, "beq1_decode");
    cyc(BR,  1, 1, 0, 0, 0, "beq1_taken");
    cyc(F,   1, 0, 0, 0, 0, "beq0_fetch");
    cyc(D,   1, 0, 0, 0, 0, "beq0_decode");
    cyc(BR,  1, 0, 0, 0, 0, "beq0_not_taken");
    b1.opcode = OP_STORE;
    cyc(F,   1, 0, 0, 0, 0, "sw_fetch");
    cyc(D,   1, 0, 0, 0, 0, "sw_decode");
    cyc(MA,  1, 0, 0, 0, 0, "sw_memadr");
    cyc(MW,  0, 0, 0, 0, 0, "sw_memwr_stall");
    cyc(MW,  1, 0, 0, 0, 0, "sw_memwr_ready");
    b1.opcode = 7'b1111111;
    cyc(F,   1, 0, 0, 0, 0, "ill_fetch");
    cyc(D,   1, 0, 0, 0, 0, "ill_decode");
    cyc(F,   1, 0, 1, 0, 0, "ill_flag_fetch");
    b1.opcode = OP_RTYPE;
    cyc(D,   1, 0, 0, 0, 0, "ill_flag_cleared");
    cyc(EX,  1, 0, 0, 0, 0, "add2_exec");
    cyc(AWB, 1, 0, 0, 0, 0, "add2_aluwb");
    b1.opcode = OP_LOAD;
    cyc(RST, 1, 0, 0, 1, 1, "rst_final");
    cyc(F,   1, 0, 0, 0, 1, "nostall_fetch");
    cyc(D,   1, 0, 0, 0, 1, "nostall_decode");
    cyc(MA,  1, 0, 0, 0, 1, "nostall_memadr");
    cyc(MR,  1, 0, 0, 0, 1, "nostall_memrd");
    cyc(MWB, 1, 0, 0, 0, 1, "nostall_memwb");
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
